// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single memory port. The data port wins
// by default; a saturating streak counter forces a fetch grant after
// MAX_D_STREAK consecutive data grants if a fetch is waiting.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  // Instruction-fetch requester
  input  logic        iReq,
  input  logic [31:0] iAddr,
  output logic [31:0] iRdata,
  output logic        iAck,
  // Load/store requester
  input  logic        dReq,
  input  logic        dWe,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  input  logic [3:0]  dMask,
  output logic [31:0] dRdata,
  output logic        dAck,
  // Shared memory port
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memMask,
  input  logic [31:0] memRdata,
  input  logic        memRdy
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  localparam logic [3:0] MaxStreak = 4'(MAX_D_STREAK);

  state_e      state_q, state_d;
  logic        own_data_q, own_data_d;  // 1: data port owns the transaction
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        we_q, we_d;
  logic [3:0]  d_streak_q, d_streak_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        pick_data;

  // Data wins unless the streak limit is reached while a fetch is waiting
  always_comb begin
    pick_data = dReq && !(iReq && (d_streak_q == MaxStreak));
  end

  // Next-state logic: grant in idle, wait for ready, one-cycle response
  always_comb begin
    state_d    = state_q;
    own_data_d = own_data_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    we_d       = we_q;
    d_streak_d = d_streak_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (iReq || dReq) begin
          state_d    = StIssue;
          own_data_d = pick_data;
          if (pick_data) begin
            addr_d  = dAddr;
            wdata_d = dWdata;
            mask_d  = dMask;
            we_d    = dWe;
            if (d_streak_q < MaxStreak) begin
              d_streak_d = d_streak_q + 4'd1;
            end
          end else begin
            addr_d     = iAddr;
            wdata_d    = '0;
            mask_d     = 4'hF;
            we_d       = 1'b0;
            d_streak_d = '0;
          end
        end
      end
      StIssue: begin
        // Request lines are not looked at here: an owner drop does not abort
        if (memRdy) begin
          state_d = StResp;
          if (own_data_q) begin
            d_rdata_d = memRdata;
          end else begin
            i_rdata_d = memRdata;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      own_data_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      we_q       <= 1'b0;
      d_streak_q <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      own_data_q <= own_data_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      we_q       <= we_d;
      d_streak_q <= d_streak_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Outputs decoded from state so reset clears them without waiting for a clock
  always_comb begin
    memReq   = (state_q == StIssue);
    memWe    = (state_q == StIssue) && we_q;
    memAddr  = addr_q;
    memWdata = wdata_q;
    memMask  = mask_q;
    iAck     = (state_q == StResp) && !own_data_q;
    dAck     = (state_q == StResp) && own_data_q;
    iRdata   = i_rdata_q;
    dRdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic.
// A driver predicts each grant from the arbitration rules and pushes the
// expected transaction; a monitor checks bus and ack behaviour against it.
module tb_mem_port_arbiter;

  localparam int MaxD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iReq = 1'b0, dReq = 1'b0, dWe = 1'b0, memRdy = 1'b0;
  logic [31:0] iAddr = '0, dAddr = '0, dWdata = '0, memRdata = '0;
  logic [3:0]  dMask = '0;
  logic [31:0] iRdata, dRdata, memAddr, memWdata;
  logic        iAck, dAck, memReq, memWe;
  logic [3:0]  memMask;

  mem_port_arbiter #(.MAX_D_STREAK(MaxD)) dut (
    .clk(clk), .reset(reset),
    .iReq(iReq), .iAddr(iAddr), .iRdata(iRdata), .iAck(iAck),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dMask(dMask),
    .dRdata(dRdata), .dAck(dAck),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memMask(memMask), .memRdata(memRdata), .memRdy(memRdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic        ack_log[$];
  int          checks = 0, failures = 0;
  int          last_len = 0;
  int          fixed_delay = -1;  // -1: random wait states
  int          spur_mode = 2;     // 0 random, 1 always, 2 never
  bit          allow_mix = 1'b0;
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] phys_mem [logic [31:0]];

  // Reference model state
  bit          pend_i = 1'b0, pend_d = 1'b0;
  logic [31:0] i_addr_m, d_addr_m, d_wdata_m;
  logic        d_we_m;
  logic [3:0]  d_mask_m;
  int          m_streak = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h1000 + (32'($urandom_range(0, 7)) << 2);
  endfunction

  task automatic raise_i(input logic [31:0] a);
    iReq = 1'b1; iAddr = a; pend_i = 1'b1; i_addr_m = a;
  endtask

  task automatic raise_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] m);
    dReq = 1'b1; dWe = we; dAddr = a; dWdata = wd; dMask = m;
    pend_d = 1'b1; d_we_m = we; d_addr_m = a; d_wdata_m = wd; d_mask_m = m;
  endtask

  // Decide the winner from the rules and queue the expected transaction
  task automatic predict(output bit win_d);
    exp_t e;
    win_d = pend_d && !(pend_i && m_streak == MaxD);
    e.is_d = win_d;
    if (win_d) begin
      e.addr = d_addr_m; e.we = d_we_m; e.wdata = d_wdata_m; e.mask = d_mask_m;
      if (m_streak < MaxD) m_streak++;
    end else begin
      e.addr = i_addr_m; e.we = 1'b0; e.wdata = '0; e.mask = 4'hF;
      m_streak = 0;
    end
    e.rdata = model_mem.exists(e.addr) ? model_mem[e.addr] : init_word(e.addr);
    if (e.we) model_mem[e.addr] = merge(e.rdata, e.wdata, e.mask);
    sb.push_back(e);
  endtask

  // Called on the negedge of an idle cycle; returns on the next idle negedge
  task automatic serve();
    bit win_d, got;
    if (!pend_i && !pend_d) begin
      @(negedge clk);
      return;
    end
    predict(win_d);
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (win_d ? dAck : iAck) begin
        got = 1'b1;
        break;
      end
      if (allow_mix) begin
        if (n == 0 && $urandom_range(0, 3) == 0) begin
          if (win_d) dReq = 1'b0; else iReq = 1'b0;
        end
        if (win_d && !pend_i && $urandom_range(0, 5) == 0) raise_i(rand_addr());
        if (!win_d && !pend_d && $urandom_range(0, 5) == 0)
          raise_d(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL ack_timeout: got no ack expected ack within 40 cycles");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
    if (win_d) begin dReq = 1'b0; pend_d = 1'b0; end
    else begin iReq = 1'b0; pend_i = 1'b0; end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_memReq", 32'(memReq), 0);
    chk("rst_memWe", 32'(memWe), 0);
    chk("rst_acks", 32'({iAck, dAck}), 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memWdata", memWdata, 0);
    chk("rst_memMask", 32'(memMask), 0);
    chk("rst_iRdata", iRdata, 0);
    chk("rst_dRdata", dRdata, 0);
  endtask

  task automatic do_reset();
    iReq = 1'b0; dReq = 1'b0; pend_i = 1'b0; pend_d = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs();
    sb.delete();
    m_streak = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Memory responder: random or fixed wait states, returns old contents, then writes
  int wait_left = -1;
  initial begin
    forever begin
      @(negedge clk);
      if (reset || !memReq) begin
        wait_left = -1;
        memRdata  = $urandom;
        memRdy    = (spur_mode == 1) ? 1'b1 :
                    (spur_mode == 2) ? 1'b0 : ($urandom_range(0, 3) == 0);
      end else begin
        if (wait_left < 0) wait_left = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
        if (wait_left == 0) begin
          memRdy   = 1'b1;
          memRdata = phys_mem.exists(memAddr) ? phys_mem[memAddr] : init_word(memAddr);
          if (memWe) phys_mem[memAddr] = merge(memRdata, memWdata, memMask);
          wait_left = -1;
        end else begin
          memRdy   = 1'b0;
          memRdata = $urandom;
          wait_left--;
        end
      end
    end
  end

  // Monitor: bus contents, stability, latency and ack/rdata against the scoreboard
  logic        mon_prev_fire = 1'b0, mon_prev_req = 1'b0, mon_we;
  logic [31:0] mon_addr, mon_wdata;
  logic [3:0]  mon_mask;
  int          mon_len = 0;
  exp_t        mon_e;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        mon_prev_fire = 1'b0; mon_prev_req = 1'b0; mon_len = 0;
        continue;
      end
      chk("ack_exclusive", 32'(iAck & dAck), 0);
      chk("ack_latency", 32'(iAck | dAck), 32'(mon_prev_fire));
      if (!memReq) chk("memWe_outside_issue", 32'(memWe), 0);
      if (memReq && !mon_prev_req) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL bus_start: got memReq expected no transaction");
        end else begin
          mon_e = sb[0];
          chk("bus_addr", memAddr, mon_e.addr);
          chk("bus_we", 32'(memWe), 32'(mon_e.we));
          chk("bus_mask", 32'(memMask), 32'(mon_e.mask));
          if (mon_e.we) chk("bus_wdata", memWdata, mon_e.wdata);
        end
        mon_addr = memAddr; mon_wdata = memWdata; mon_mask = memMask; mon_we = memWe;
        mon_len = 0;
      end else if (memReq) begin
        chk("bus_stable", {memAddr ^ mon_addr} | {memWdata ^ mon_wdata} |
            32'({memMask ^ mon_mask, memWe ^ mon_we}), 0);
      end
      if (memReq) mon_len++;
      if (!memReq && mon_prev_req) last_len = mon_len;
      if (iAck || dAck) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL ack_unexpected: got ack i=%0b d=%0b expected none", iAck, dAck);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_owner", 32'(dAck), 32'(mon_e.is_d));
          chk("ack_rdata", mon_e.is_d ? dRdata : iRdata, mon_e.rdata);
          ack_log.push_back(dAck);
        end
      end
      mon_prev_fire = memReq & memRdy;
      mon_prev_req  = memReq;
    end
  end

  // Stimulus
  logic [9:0]  order_pat;
  logic [9:0]  order_got;
  logic [31:0] save_i, save_d;
  bit          wd;
  initial begin
    do_reset();

    // Single fetch, ready on the first issue cycle
    fixed_delay = 0;
    model_mem[32'h100] = 32'hDEADBEEF;
    phys_mem[32'h100]  = 32'hDEADBEEF;
    raise_i(32'h100);
    serve();
    chk("fetch_req_len", 32'(last_len), 1);
    chk("fetch_iRdata", iRdata, 32'hDEADBEEF);

    // Data write with three wait states
    fixed_delay = 3;
    raise_d(1'b1, 32'h2000, 32'h12345678, 4'b0011);
    serve();
    chk("write_req_len", 32'(last_len), 4);
    chk("write_dRdata", dRdata, init_word(32'h2000));

    // Spurious ready while idle
    save_i = iRdata; save_d = dRdata;
    spur_mode = 1;
    repeat (4) begin
      @(negedge clk);
      #2 chk("spur_memReq", 32'(memReq), 0);
    end
    spur_mode = 2;
    @(negedge clk);
    chk("spur_iRdata", iRdata, save_i);
    chk("spur_dRdata", dRdata, save_d);

    // Simultaneous requests after reset: data first, fetch once dReq drops
    fixed_delay = 1;
    do_reset();
    ack_log.delete();
    raise_i(32'h1004);
    raise_d(1'b0, 32'h1008, 32'h0, 4'hF);
    serve();
    serve();
    chk("simul_count", 32'(ack_log.size()), 2);
    if (ack_log.size() == 2) chk("simul_order", 32'({ack_log[0], ack_log[1]}), 32'b10);

    // Starvation guard with both requests held
    fixed_delay = -1;
    do_reset();
    ack_log.delete();
    for (int r = 0; r < 10; r++) begin
      if (!pend_i) raise_i(rand_addr());
      if (!pend_d) raise_d(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'hF);
      serve();
    end
    order_pat = 10'b01111_01111;  // bit 0 = first grant, 1 = data
    order_got = '0;
    for (int k = 0; k < 10 && k < ack_log.size(); k++) order_got[k] = ack_log[k];
    chk("starve_count", 32'(ack_log.size()), 10);
    chk("starve_order", 32'(order_got), 32'(order_pat));

    // Reset two cycles into a data transaction
    do_reset();
    fixed_delay = 10;
    raise_d(1'b1, 32'h3000, 32'hCAFEF00D, 4'hF);
    predict(wd);
    @(negedge clk);
    chk("midrst_issue", 32'(memReq), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("midrst_memReq_async", 32'(memReq), 0);
    check_reset_outputs();
    dReq = 1'b0; pend_d = 1'b0;
    sb.delete();
    model_mem.delete(32'h3000);
    m_streak = 0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_dAck", 32'(dAck), 0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_idle_memReq", 32'(memReq), 0);
    chk("midrst_idle_ack", 32'({iAck, dAck}), 0);

    // Randomized traffic with wait states, spurious ready and mid-transaction changes
    fixed_delay = -1;
    spur_mode = 0;
    allow_mix = 1'b1;
    for (int r = 0; r < 250; r++) begin
      if (!pend_i && $urandom_range(0, 1) == 1) raise_i(rand_addr());
      if (!pend_d && $urandom_range(0, 1) == 1)
        raise_d(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
      serve();
    end
    allow_mix = 1'b0;
    spur_mode = 2;
    while (pend_i || pend_d) serve();
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    checks++; failures++;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_D_STREAK, default 4: the maximum number of consecutive data grants while a fetch is pending (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have ports iReq (in, 1), iAddr (in, 32), iRdata (out, 32) and iAck (out, 1): the instruction-fetch requester.
REQ-005 The block SHALL have ports dReq (in, 1), dWe (in, 1), dAddr (in, 32), dWdata (in, 32), dMask (in, 4), dRdata (out, 32) and dAck (out, 1): the load/store requester.
REQ-006 The block SHALL have ports memReq (out, 1), memWe (out, 1), memAddr (out, 32), memWdata (out, 32), memMask (out, 4), memRdata (in, 32) and memRdy (in, 1): the single shared memory port.

Function
REQ-007 The FSM SHALL have exactly three states: IDLE, ISSUE and RESP.
REQ-008 In IDLE with neither request high, the FSM SHALL stay in IDLE.
REQ-009 In IDLE with any request high, the FSM SHALL select an owner, latch the owner's address, data, mask and write enable into internal registers, and go to ISSUE on the next edge.
REQ-010 Arbitration SHALL grant data priority when both requests are high, except when dStreak == MAX_D_STREAK and iReq = 1, in which case fetch SHALL win.
REQ-011 dStreak SHALL be a 4-bit counter that increments on each data grant, saturates at MAX_D_STREAK, and clears to 0 on each fetch grant.
REQ-012 In ISSUE, memReq SHALL be 1 and memAddr/memWdata/memMask/memWe SHALL drive the latched values; for a fetch, memWe SHALL be 0 and memMask SHALL be 4'b1111.
REQ-013 Outside ISSUE, memReq and memWe SHALL be 0.
REQ-014 The FSM SHALL stay in ISSUE while memRdy = 0, with no timeout.
REQ-015 On a cycle in ISSUE with memRdy = 1, the block SHALL capture memRdata into the owner's rdata register and move to RESP.
REQ-016 In RESP, the owner's ack SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-017 iAck and dAck SHALL never be 1 in the same cycle.
REQ-018 iRdata/dRdata SHALL hold their last captured value until the next completion for that requester; a data write SHALL still update dRdata with memRdata.
REQ-019 Latency SHALL be: request sampled in IDLE at edge N; memReq high from cycle N+1; memRdy seen at cycle N+k (k ≥ 1); ack high in cycle N+k+1; next grant sampled no earlier than cycle N+k+2.
REQ-020 A requester SHALL hold its request and payload stable until it sees ack, and SHALL deassert the request in the cycle after ack unless it is issuing a new request.
REQ-021 The block SHALL ignore request-line changes by the non-owner during ISSUE/RESP; those changes SHALL only be evaluated in IDLE.
REQ-022 A request dropped by the owner during ISSUE SHALL NOT abort the memory transaction, and the ack SHALL still be issued.
REQ-023 A memRdy pulse in IDLE or RESP SHALL be ignored.

Reset
REQ-024 While reset = 1, regardless of clk, the FSM SHALL be IDLE; dStreak SHALL be 0; memReq, memWe, iAck and dAck SHALL be 0; and memAddr, memWdata, memMask, iRdata and dRdata SHALL be 0.
REQ-025 Reset asserted during ISSUE or RESP SHALL abandon the transaction with no ack issued.
REQ-026 After reset deasserts, the first grant SHALL follow REQ-010 with dStreak = 0.

Verification
REQ-027 The bench SHALL cover single fetch: iReq = 1, iAddr = 0x100, memRdy = 1 on the first ISSUE cycle with memRdata = 0xDEADBEEF -> memReq one cycle with memAddr = 0x100, memMask = 4'hF, memWe = 0, then iAck one cycle with iRdata = 0xDEADBEEF.
REQ-028 The bench SHALL cover a data write with wait states: dReq = 1, dWe = 1, dAddr = 0x2000, dWdata = 0x12345678, dMask = 4'b0011, memRdy delayed 3 cycles -> memReq high for 4 cycles with stable outputs, then one dAck pulse.
REQ-029 The bench SHALL cover starvation guard: with MAX_D_STREAK = 4 and iReq, dReq held high, the grant order SHALL be D, D, D, D, I, D, D, D, D, I.
REQ-030 The bench SHALL cover simultaneous requests after reset: both requests high -> data granted first and fetch granted next once dReq drops.
REQ-031 The bench SHALL cover reset mid-ISSUE: assert reset 2 cycles into a data transaction -> memReq = 0 immediately (asynchronous), no dAck, and the FSM in IDLE after release.
REQ-032 The bench SHALL cover spurious ready: memRdy = 1 while IDLE with no request -> no ack, no state change, and rdata registers unchanged.
